// File: rtl/shift_pkg.sv
// Shared encodings for the sequenced shift register: mode codes and FSM states.
package shift_pkg;

  // Shift mode encoding; codes 5-7 are reserved and behave as a zero-length shift.
  localparam logic [2:0] SH_SLL = 3'd0;
  localparam logic [2:0] SH_SRL = 3'd1;
  localparam logic [2:0] SH_SRA = 3'd2;
  localparam logic [2:0] SH_ROL = 3'd3;
  localparam logic [2:0] SH_ROR = 3'd4;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational barrel stage: shifts value by s (0..STEP) bits in the given mode
// and reports the last bit that left the register.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned STEP = 1,
  localparam int unsigned SW = $clog2(STEP + 1)
) (
  input  logic [N-1:0]  value,
  input  logic [2:0]    mode,
  input  logic [SW-1:0] s,
  input  logic          sin,
  output logic [N-1:0]  result,
  output logic          out_bit
);

  // One shift of s bits; s == 0 passes value through and out_bit is meaningless.
  always_comb begin
    int unsigned sh;
    logic [N-1:0] tmp;
    sh      = 32'(s);
    tmp     = '0;
    result  = value;
    out_bit = 1'b0;
    if (sh != 0) begin
      case (mode)
        SH_SLL: begin
          result = (value << s) | (sin ? ~({N{1'b1}} << s) : '0);
          tmp    = value >> (N - sh);
        end
        SH_SRL: begin
          result = (value >> s) | (sin ? ~({N{1'b1}} >> s) : '0);
          tmp    = value >> (sh - 1);
        end
        SH_SRA: begin
          result = $unsigned($signed(value) >>> s);
          tmp    = value >> (sh - 1);
        end
        SH_ROL: begin
          result = (value << s) | (value >> (N - sh));
          tmp    = value >> (N - sh);
        end
        SH_ROR: begin
          result = (value >> s) | (value << (N - sh));
          tmp    = value >> (sh - 1);
        end
        default: begin
          result = value;
          tmp    = '0;
        end
      endcase
      out_bit = tmp[0];
    end
  end

endmodule

// File: rtl/shift_register_seq.sv
// Operand register with legacy load/shift-left plus a sequenced multi-bit shift
// engine (start/busy/done handshake), STEP bits per cycle at most.
module shift_register_seq
  import shift_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned STEP = 1,
  localparam int unsigned AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [N-1:0]  pin,
  input  logic          shl,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic          sin,
  output logic [N-1:0]  pout,
  output logic          sout,
  output logic          busy,
  output logic          done,
  output logic          zero
);

  localparam int unsigned SW = $clog2(STEP + 1);

  state_e        state_q, state_d;
  logic [N-1:0]  pout_q, pout_d;
  logic          sout_q, sout_d;
  logic          done_q, done_d;
  logic [2:0]    mode_q, mode_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] amt_eff;
  logic [SW-1:0] step_s;
  logic [N-1:0]  step_res;
  logic          step_bit;

  // Effective shift length: linear shifts saturate at N, rotates wrap modulo N.
  always_comb begin
    int unsigned a;
    a = 32'(amt);
    case (mode)
      SH_SLL, SH_SRL, SH_SRA: amt_eff = (a > N) ? AW'(N) : amt;
      SH_ROL, SH_ROR:         amt_eff = AW'(a % N);
      default:                amt_eff = '0;
    endcase
  end

  // Bits shifted this cycle: the smaller of STEP and what is left.
  always_comb begin
    if (rem_q > AW'(STEP)) step_s = SW'(STEP);
    else                   step_s = SW'(rem_q);
  end

  shift_step_unit #(
    .N    (N),
    .STEP (STEP)
  ) u_step (
    .value   (pout_q),
    .mode    (mode_q),
    .s       (step_s),
    .sin     (sin),
    .result  (step_res),
    .out_bit (step_bit)
  );

  // Next-state logic: IDLE priority ld > start > shl; in SHIFT ld aborts silently.
  always_comb begin
    state_d = state_q;
    pout_d  = pout_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (ld) begin
          pout_d = pin;
        end else if (start) begin
          mode_d  = mode;
          rem_d   = amt_eff;
          state_d = StShift;
        end else if (shl) begin
          pout_d = {pout_q[N-2:0], 1'b0};
          sout_d = pout_q[N-1];
        end
      end
      StShift: begin
        if (ld) begin
          pout_d  = pin;
          state_d = StIdle;
        end else if (rem_q == '0) begin
          // Zero-length shift: finish without touching pout or sout.
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          pout_d = step_res;
          sout_d = step_bit;
          rem_d  = rem_q - AW'(step_s);
          if (rem_d == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pout_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= SH_SLL;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      pout_q  <= pout_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  assign pout = pout_q;
  assign sout = sout_q;
  assign busy = (state_q == StShift);
  assign done = done_q;
  assign zero = (pout_q == '0);

endmodule

// File: tb/tb_shift_register_seq.sv
// Self-checking bench: two instances (STEP=1 and STEP=4), table vectors,
// hand-written corner sequences and randomized ops against a bit-serial model.
module tb_shift_register_seq;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_a = 1'b0, ld_b = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] pin = '0;
  logic        shl = 1'b0;
  logic [2:0]  mode = '0;
  logic [4:0]  amt = '0;
  logic        sin = 1'b0;
  logic [15:0] pout_a, pout_b;
  logic        sout_a, sout_b, busy_a, busy_b, done_a, done_b, zero_a, zero_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_register_seq #(.N(16), .STEP(1)) u_dut_a (
    .clk(clk), .rst(rst), .ld(ld_a), .pin(pin), .shl(shl), .start(start_a),
    .mode(mode), .amt(amt), .sin(sin), .pout(pout_a), .sout(sout_a),
    .busy(busy_a), .done(done_a), .zero(zero_a)
  );

  shift_register_seq #(.N(16), .STEP(4)) u_dut_b (
    .clk(clk), .rst(rst), .ld(ld_b), .pin(pin), .shl(shl), .start(start_b),
    .mode(mode), .amt(amt), .sin(sin), .pout(pout_b), .sout(sout_b),
    .busy(busy_b), .done(done_b), .zero(zero_b)
  );

  typedef struct {
    logic [15:0] init;
    logic [2:0]  m;
    logic [4:0]  am;
    logic        s_in;
    logic [15:0] exp_pout;
    logic        exp_sout;
    logic        chk_sout;
    int          cyc_a;
    int          cyc_b;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: apply the whole shift one bit at a time, tracking the bit that falls out.
  task automatic model(input logic [15:0] v, input logic [2:0] m, input int unsigned am,
                       input logic s_in, output logic [15:0] res, output int unsigned a,
                       output logic ob);
    res = v;
    ob  = 1'b0;
    if (m <= 3'd2)      a = (am > N) ? N : am;
    else if (m <= 3'd4) a = am % N;
    else                a = 0;
    for (int k = 0; k < int'(a); k++) begin
      case (m)
        3'd0: begin ob = res[15]; res = {res[14:0], s_in}; end
        3'd1: begin ob = res[0];  res = {s_in, res[15:1]}; end
        3'd2: begin ob = res[0];  res = {res[15], res[15:1]}; end
        3'd3: begin ob = res[15]; res = {res[14:0], res[15]}; end
        default: begin ob = res[0]; res = {res[0], res[15:1]}; end
      endcase
    end
  endtask

  // Load both instances, start the same shift on both, watch busy/done until both finish.
  task automatic run_op(input string tag, input logic [15:0] init, input logic [2:0] m,
                        input logic [4:0] am, input logic s_in, input logic [15:0] exp_pout,
                        input logic exp_sout, input logic chk_sout, input int cyc_a,
                        input int cyc_b);
    int bca, bcb, dca, dcb, ov;
    logic fin;
    bca = 0; bcb = 0; dca = 0; dcb = 0; ov = 0; fin = 1'b0;
    ld_a = 1'b1; ld_b = 1'b1; pin = init;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
    mode = m; amt = am; sin = s_in; start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (busy_a) bca++;
      if (busy_b) bcb++;
      if (done_a) dca++;
      if (done_b) dcb++;
      if ((busy_a && done_a) || (busy_b && done_b)) ov++;
      if (dca > 0 && dcb > 0 && !busy_a && !busy_b) begin
        fin = 1'b1;
        break;
      end
      tick();
    end
    tick();
    if (done_a) dca++;
    if (done_b) dcb++;
    check({tag, " finished"}, 32'(fin), 32'd1);
    check({tag, " pout_a"}, 32'(pout_a), 32'(exp_pout));
    check({tag, " pout_b"}, 32'(pout_b), 32'(exp_pout));
    check({tag, " zero_a"}, 32'(zero_a), 32'(exp_pout == 16'h0));
    if (chk_sout) begin
      check({tag, " sout_a"}, 32'(sout_a), 32'(exp_sout));
      check({tag, " sout_b"}, 32'(sout_b), 32'(exp_sout));
    end
    check({tag, " busy cycles a"}, 32'(bca), 32'(cyc_a));
    check({tag, " busy cycles b"}, 32'(bcb), 32'(cyc_b));
    check({tag, " done pulses a"}, 32'(dca), 32'd1);
    check({tag, " done pulses b"}, 32'(dcb), 32'd1);
    check({tag, " busy&done overlap"}, 32'(ov), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[12];
    int bc, dc;
    logic [15:0] r_init, r_exp;
    logic [2:0]  r_m;
    logic [4:0]  r_am;
    logic        r_sin, r_ob;
    int unsigned r_a;

    tbl[0]  = '{16'h00F0, 3'd0, 5'd4,  1'b1, 16'h0F0F, 1'b0, 1'b1, 4,  1};
    tbl[1]  = '{16'hF000, 3'd2, 5'd9,  1'b0, 16'hFFF8, 1'b0, 1'b1, 9,  3};
    tbl[2]  = '{16'h1234, 3'd4, 5'd20, 1'b0, 16'h4123, 1'b0, 1'b1, 4,  1};
    tbl[3]  = '{16'h1234, 3'd3, 5'd16, 1'b0, 16'h1234, 1'b0, 1'b0, 1,  1};
    tbl[4]  = '{16'hA5A5, 3'd1, 5'd31, 1'b0, 16'h0000, 1'b1, 1'b1, 16, 4};
    tbl[5]  = '{16'h8001, 3'd0, 5'd1,  1'b0, 16'h0002, 1'b1, 1'b1, 1,  1};
    tbl[6]  = '{16'h1234, 3'd5, 5'd3,  1'b1, 16'h1234, 1'b0, 1'b0, 1,  1};
    tbl[7]  = '{16'h8000, 3'd3, 5'd1,  1'b0, 16'h0001, 1'b1, 1'b1, 1,  1};
    tbl[8]  = '{16'h0001, 3'd1, 5'd16, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16, 4};
    tbl[9]  = '{16'h00FF, 3'd0, 5'd5,  1'b0, 16'h1FE0, 1'b0, 1'b1, 5,  2};
    tbl[10] = '{16'h8421, 3'd2, 5'd3,  1'b1, 16'hF084, 1'b0, 1'b1, 3,  1};
    tbl[11] = '{16'h8421, 3'd4, 5'd15, 1'b0, 16'h0843, 1'b0, 1'b1, 15, 4};

    // Reset held with ld asserted: register must stay cleared.
    ld_a = 1'b1; ld_b = 1'b1; pin = 16'hFFFF;
    tick(); tick();
    check("reset pout_a", 32'(pout_a), 32'h0);
    check("reset pout_b", 32'(pout_b), 32'h0);
    check("reset sout_a", 32'(sout_a), 32'h0);
    check("reset busy_a", 32'(busy_a), 32'h0);
    check("reset done_a", 32'(done_a), 32'h0);
    check("reset zero_a", 32'(zero_a), 32'h1);
    rst = 1'b1;
    pin = 16'h8001;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
    check("legacy ld pout_a", 32'(pout_a), 32'h8001);
    check("legacy ld zero_a", 32'(zero_a), 32'h0);
    shl = 1'b1;
    tick();
    shl = 1'b0;
    check("legacy shl pout_a", 32'(pout_a), 32'h0002);
    check("legacy shl sout_a", 32'(sout_a), 32'h1);
    check("legacy shl pout_b", 32'(pout_b), 32'h0002);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].init, tbl[i].m, tbl[i].am, tbl[i].s_in,
             tbl[i].exp_pout, tbl[i].exp_sout, tbl[i].chk_sout, tbl[i].cyc_a, tbl[i].cyc_b);
    end

    // start while busy is ignored: one done, length of the first request.
    ld_a = 1'b1; pin = 16'h0001;
    tick();
    ld_a = 1'b0;
    mode = 3'd0; amt = 5'd8; sin = 1'b0; start_a = 1'b1;
    tick();
    bc = 0; dc = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy_a) bc++;
      if (done_a) dc++;
      start_a = (c == 2);
      if (c == 2) begin
        mode = 3'd1; amt = 5'd2;
      end
      tick();
    end
    start_a = 1'b0;
    check("ignored start busy cycles", 32'(bc), 32'd8);
    check("ignored start done pulses", 32'(dc), 32'd1);
    check("ignored start pout_a", 32'(pout_a), 32'h0100);

    // ld during the second step aborts: new data, idle, no done.
    ld_a = 1'b1; pin = 16'h00FF;
    tick();
    ld_a = 1'b0;
    mode = 3'd0; amt = 5'd8; sin = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    ld_a = 1'b1; pin = 16'hABCD;
    tick();
    ld_a = 1'b0;
    check("abort pout_a", 32'(pout_a), 32'hABCD);
    check("abort busy_a", 32'(busy_a), 32'h0);
    dc = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_a) dc++;
      tick();
    end
    check("abort done pulses", 32'(dc), 32'd0);
    check("abort pout_a held", 32'(pout_a), 32'hABCD);

    // Asynchronous reset mid-shift clears outputs between clock edges.
    ld_a = 1'b1; pin = 16'h1234;
    tick();
    ld_a = 1'b0;
    mode = 3'd0; amt = 5'd8; sin = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick();
    check("pre-reset busy_a", 32'(busy_a), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async reset pout_a", 32'(pout_a), 32'h0);
    check("async reset busy_a", 32'(busy_a), 32'h0);
    check("async reset sout_a", 32'(sout_a), 32'h0);
    check("async reset done_a", 32'(done_a), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("post-reset busy_a", 32'(busy_a), 32'h0);
    check("post-reset done_a", 32'(done_a), 32'h0);
    sin = 1'b0;

    // Randomized ops against the bit-serial model.
    for (int i = 0; i < 60; i++) begin
      r_init = 16'($urandom);
      r_m    = 3'($urandom_range(0, 7));
      r_am   = 5'($urandom_range(0, 31));
      r_sin  = 1'($urandom_range(0, 1));
      model(r_init, r_m, 32'(r_am), r_sin, r_exp, r_a, r_ob);
      run_op($sformatf("rand%0d", i), r_init, r_m, r_am, r_sin, r_exp, r_ob, r_a != 0,
             (r_a == 0) ? 1 : int'(r_a), (r_a == 0) ? 1 : int'((r_a + 3) / 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
